// File: rtl/clock_pkg.sv
// Shared key-controller codes, time/date bus layouts, FSM states and reset values
// for the clock edit path.
package clock_pkg;

    localparam int TIME_W = 17;
    localparam int DATE_W = 16;

    // Time bus: [16] PM, [15:12] hour, [11:6] min, [5:0] sec
    localparam int T_PM_POS   = 16;
    localparam int T_HOUR_POS = 12;
    localparam int T_HOUR_W   = 4;
    localparam int T_MIN_POS  = 6;
    localparam int T_MIN_W    = 6;
    localparam int T_SEC_POS  = 0;
    localparam int T_SEC_W    = 6;

    // Date bus: [15:9] year (2000+), [8:5] month, [4:0] day
    localparam int D_YEAR_POS  = 9;
    localparam int D_YEAR_W    = 7;
    localparam int D_MONTH_POS = 5;
    localparam int D_MONTH_W   = 4;
    localparam int D_DAY_POS   = 0;
    localparam int D_DAY_W     = 5;

    localparam logic [2:0] FLAG_NONE   = 3'b000;
    localparam logic [2:0] FLAG_TIME   = 3'b010;
    localparam logic [2:0] FLAG_ALARM  = 3'b011;
    localparam logic [2:0] FLAG_DONE   = 3'b100;
    localparam logic [2:0] FLAG_CANCEL = 3'b101;

    localparam logic [2:0] FIELD_NONE     = 3'b000;
    localparam logic [2:0] FIELD_HOUR     = 3'b001;
    localparam logic [2:0] FIELD_MIN      = 3'b010;
    localparam logic [2:0] FIELD_SEC      = 3'b011;
    localparam logic [2:0] FIELD_MERIDIAN = 3'b100;
    localparam logic [2:0] FIELD_YEAR     = 3'b101;
    localparam logic [2:0] FIELD_MONTH    = 3'b110;
    localparam logic [2:0] FIELD_DAY      = 3'b111;

    localparam logic [TIME_W-1:0] TIME_RST = 17'h0C000;
    localparam logic [DATE_W-1:0] DATE_RST = 16'h0021;

    typedef struct packed {
        logic                pm;
        logic [T_HOUR_W-1:0] hour;
        logic [T_MIN_W-1:0]  min;
        logic [T_SEC_W-1:0]  sec;
    } clk_time_t;

    typedef struct packed {
        logic [D_YEAR_W-1:0]  year;
        logic [D_MONTH_W-1:0] month;
        logic [D_DAY_W-1:0]   day;
    } clk_date_t;

    typedef enum logic [1:0] {IDLE, EDIT_T, EDIT_A, COMMIT} state_t;

    // One step up or down inside [lo, hi], wrapping at both ends.
    function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] lo,
                                             input logic [6:0] hi, input logic up);
        if (up)
            return (v >= hi) ? lo : v + 7'd1;
        else
            return (v <= lo) ? hi : v - 7'd1;
    endfunction

endpackage

// File: rtl/time_edit_ctrl_if.sv
// Key-controller / time-keeper signals seen by the edit engine.
interface time_edit_ctrl_if;
    import clock_pkg::*;

    logic [2:0]        FLAG;
    logic [2:0]        FIELD;
    logic              INC;
    logic              DEC;
    logic [TIME_W-1:0] CUR_TIME;
    logic [DATE_W-1:0] CUR_DATE;
    logic [TIME_W-1:0] ALARM_TIME;
    logic [TIME_W-1:0] EDIT_TIME;
    logic [DATE_W-1:0] EDIT_DATE;
    logic              EDITING;
    logic              LOAD_TIME;
    logic              LOAD_ALARM;

    modport master (
        output FLAG, FIELD, INC, DEC, CUR_TIME, CUR_DATE, ALARM_TIME,
        input  EDIT_TIME, EDIT_DATE, EDITING, LOAD_TIME, LOAD_ALARM
    );

    modport slave (
        input  FLAG, FIELD, INC, DEC, CUR_TIME, CUR_DATE, ALARM_TIME,
        output EDIT_TIME, EDIT_DATE, EDITING, LOAD_TIME, LOAD_ALARM
    );
endinterface

// File: rtl/time_edit_ctrl_days_in_month.sv
// Days in a month for years 2000..2099 (every year divisible by 4 is leap).
module days_in_month
    import clock_pkg::*;
(
    input  logic [D_MONTH_W-1:0] month,
    input  logic [D_YEAR_W-1:0]  year,
    output logic [D_DAY_W-1:0]   days
);
    always_comb begin
        case (month)
            4'd2:                    days = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
            default:                 days = 5'd31;
        endcase
    end
endmodule

// File: rtl/time_edit_ctrl.sv
// Edit engine: snapshots time or alarm into a shadow register, applies field-wise
// wrap-around edits, and commits with a one-cycle load strobe or discards.
module time_edit_ctrl
    import clock_pkg::*;
(
    input  logic            CLK,
    input  logic            RESETN,
    time_edit_ctrl_if.slave bus
);
    state_t               state, state_nxt;
    logic                 armed, tgt_alarm;
    logic                 load_time_q, load_alarm_q, load_time_d, load_alarm_d, editing;
    clk_time_t            shadow_t, shadow_t_nxt, cur_t, alarm_t;
    clk_date_t            shadow_d, shadow_d_nxt, cur_d;
    logic                 is_edit_flag, in_edit, snap, apply, date_ok, up;
    logic [D_MONTH_W-1:0] cand_month;
    logic [D_YEAR_W-1:0]  cand_year;
    logic [D_DAY_W-1:0]   dim;

    assign cur_t   = bus.CUR_TIME;
    assign cur_d   = bus.CUR_DATE;
    assign alarm_t = bus.ALARM_TIME;

    assign is_edit_flag = (bus.FLAG == FLAG_TIME) || (bus.FLAG == FLAG_ALARM);
    assign in_edit      = (state == EDIT_T) || (state == EDIT_A);
    assign snap         = (state == IDLE) && is_edit_flag && armed;
    // Only a live edit code carries a strobe; DONE/CANCEL/abort in the same cycle drop it.
    assign apply        = in_edit && is_edit_flag && (bus.INC ^ bus.DEC);
    assign date_ok      = apply && (state == EDIT_T);
    assign up           = bus.INC;

    // Month/year after this cycle's edit; the day limit is looked up on these.
    assign cand_year  = (date_ok && bus.FIELD == FIELD_YEAR)
                      ? wrap_step(shadow_d.year, 7'd0, 7'd99, up)
                      : shadow_d.year;
    assign cand_month = (date_ok && bus.FIELD == FIELD_MONTH)
                      ? D_MONTH_W'(wrap_step(7'(shadow_d.month), 7'd1, 7'd12, up))
                      : shadow_d.month;

    days_in_month u_dim (
        .month (cand_month),
        .year  (cand_year),
        .days  (dim)
    );

    // NOTE: every variable gets a default at the top of a combinational block so no latch is inferred.
    always_comb begin
        shadow_t_nxt       = shadow_t;
        shadow_d_nxt       = shadow_d;
        shadow_d_nxt.year  = cand_year;
        shadow_d_nxt.month = cand_month;
        if (apply) begin
            case (bus.FIELD)
                FIELD_HOUR:     shadow_t_nxt.hour = T_HOUR_W'(wrap_step(7'(shadow_t.hour), 7'd1, 7'd12, up));
                FIELD_MIN:      shadow_t_nxt.min  = T_MIN_W'(wrap_step(7'(shadow_t.min), 7'd0, 7'd59, up));
                FIELD_SEC:      shadow_t_nxt.sec  = T_SEC_W'(wrap_step(7'(shadow_t.sec), 7'd0, 7'd59, up));
                FIELD_MERIDIAN: shadow_t_nxt.pm   = ~shadow_t.pm;
                default:        ;
            endcase
        end
        if (date_ok && bus.FIELD == FIELD_DAY)
            shadow_d_nxt.day = D_DAY_W'(wrap_step(7'(shadow_d.day), 7'd1, 7'(dim), up));
        else if (date_ok && (bus.FIELD == FIELD_MONTH || bus.FIELD == FIELD_YEAR) && shadow_d.day > dim)
            shadow_d_nxt.day = dim;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:           if (snap) state_nxt = (bus.FLAG == FLAG_ALARM) ? EDIT_A : EDIT_T;
            EDIT_T, EDIT_A: if (bus.FLAG == FLAG_DONE) state_nxt = COMMIT;
                            else if (!is_edit_flag)    state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        editing      = (state != IDLE);
        load_time_d  = (state == COMMIT) && !tgt_alarm;
        load_alarm_d = (state == COMMIT) && tgt_alarm;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: RESETN is synchronous: it is only examined on the rising CLK edge.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state        <= IDLE;
            load_time_q  <= 1'b0;
            load_alarm_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            load_time_q  <= load_time_d;
            load_alarm_q <= load_alarm_d;
        end
    end

    // A held edit code must leave and re-enter before it opens another session.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            armed     <= 1'b0;
            tgt_alarm <= 1'b0;
        end else begin
            if (!is_edit_flag) armed <= 1'b1;
            else if (snap)     armed <= 1'b0;
            if (snap) tgt_alarm <= (bus.FLAG == FLAG_ALARM);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            shadow_t <= TIME_RST;
            shadow_d <= DATE_RST;
        end else if (snap) begin
            shadow_t <= (bus.FLAG == FLAG_ALARM) ? alarm_t : cur_t;
            if (bus.FLAG == FLAG_TIME) shadow_d <= cur_d;
        end else begin
            shadow_t <= shadow_t_nxt;
            shadow_d <= shadow_d_nxt;
        end
    end

    assign bus.EDIT_TIME  = shadow_t;
    assign bus.EDIT_DATE  = shadow_d;
    assign bus.EDITING    = editing;
    assign bus.LOAD_TIME  = load_time_q;
    assign bus.LOAD_ALARM = load_alarm_q;
endmodule

// File: tb/tb_time_edit_ctrl.sv
// Scenario bench for time_edit_ctrl: each step queues the outputs expected after
// the next edge, and a negedge monitor pops and compares them.
module tb_time_edit_ctrl;
    import clock_pkg::*;

    logic CLK = 1'b0;
    logic RESETN;

    time_edit_ctrl_if bus();

    time_edit_ctrl dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [16:0] t;
        logic [15:0] d;
        logic        ed;
        logic        lt;
        logic        la;
    } exp_s;

    exp_s        sb[$];
    string       sb_tag[$];
    int          errors = 0;
    int          checks = 0;
    logic [16:0] exp_time;
    logic [15:0] exp_date;
    logic        exp_ed, exp_lt, exp_la;
    string       cur_tag;
    exp_s        mon_e;
    string       mon_tag;

    function automatic logic [16:0] mk_time(input logic pm, input int h, input int m, input int s);
        return {pm, 4'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [15:0] mk_date(input int y, input int mo, input int d);
        return {7'(y), 4'(mo), 5'(d)};
    endfunction

    // Scoreboard monitor: compares DUT outputs half a cycle after the edge they follow.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_tag = sb_tag.pop_front();
            checks++;
            if (bus.EDIT_TIME !== mon_e.t) begin
                errors++;
                $display("FAIL %s EDIT_TIME got %h want %h", mon_tag, bus.EDIT_TIME, mon_e.t);
            end
            checks++;
            if (bus.EDIT_DATE !== mon_e.d) begin
                errors++;
                $display("FAIL %s EDIT_DATE got %h want %h", mon_tag, bus.EDIT_DATE, mon_e.d);
            end
            checks++;
            if (bus.EDITING !== mon_e.ed) begin
                errors++;
                $display("FAIL %s EDITING got %b want %b", mon_tag, bus.EDITING, mon_e.ed);
            end
            checks++;
            if (bus.LOAD_TIME !== mon_e.lt) begin
                errors++;
                $display("FAIL %s LOAD_TIME got %b want %b", mon_tag, bus.LOAD_TIME, mon_e.lt);
            end
            checks++;
            if (bus.LOAD_ALARM !== mon_e.la) begin
                errors++;
                $display("FAIL %s LOAD_ALARM got %b want %b", mon_tag, bus.LOAD_ALARM, mon_e.la);
            end
        end
    end

    task automatic step(input logic [2:0] flag, input logic [2:0] field, input logic inc, input logic dec);
        exp_s e;
        bus.FLAG  = flag;
        bus.FIELD = field;
        bus.INC   = inc;
        bus.DEC   = dec;
        e.t  = exp_time;
        e.d  = exp_date;
        e.ed = exp_ed;
        e.lt = exp_lt;
        e.la = exp_la;
        sb.push_back(e);
        sb_tag.push_back(cur_tag);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        cur_tag  = "reset";
        RESETN   = 1'b0;
        exp_time = 17'h0C000;
        exp_date = 16'h0021;
        exp_ed   = 1'b0;
        exp_lt   = 1'b0;
        exp_la   = 1'b0;
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
        RESETN = 1'b1;
        step(FLAG_NONE, FIELD_HOUR, 1'b1, 1'b0);
    endtask

    task automatic test_snapshot();
        cur_tag        = "snapshot";
        bus.CUR_TIME   = mk_time(1'b0, 11, 59, 30);
        bus.CUR_DATE   = mk_date(24, 2, 29);
        bus.ALARM_TIME = mk_time(1'b1, 6, 30, 0);
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
        exp_time = mk_time(1'b0, 11, 59, 30);
        exp_date = mk_date(24, 2, 29);
        exp_ed   = 1'b1;
        step(FLAG_TIME, FIELD_NONE, 1'b0, 1'b0);
        cur_tag      = "snapshot_hold";
        bus.CUR_TIME = mk_time(1'b1, 12, 0, 0);
        step(FLAG_TIME, FIELD_NONE, 1'b0, 1'b0);
        checks++;
        if (bus.EDIT_TIME !== mk_time(1'b0, 11, 59, 30)) begin
            errors++;
            $display("FAIL snapshot_frozen EDIT_TIME got %h want %h", bus.EDIT_TIME, mk_time(1'b0, 11, 59, 30));
        end
    endtask

    task automatic test_wrap();
        cur_tag = "min_inc_wrap";  exp_time = mk_time(1'b0, 11, 0, 30);  step(FLAG_TIME, FIELD_MIN, 1'b1, 1'b0);
        cur_tag = "min_dec_wrap";  exp_time = mk_time(1'b0, 11, 59, 30); step(FLAG_TIME, FIELD_MIN, 1'b0, 1'b1);
        cur_tag = "hour_inc";      exp_time = mk_time(1'b0, 12, 59, 30); step(FLAG_TIME, FIELD_HOUR, 1'b1, 1'b0);
        cur_tag = "hour_inc_wrap"; exp_time = mk_time(1'b0, 1, 59, 30);  step(FLAG_TIME, FIELD_HOUR, 1'b1, 1'b0);
        cur_tag = "hour_dec_wrap"; exp_time = mk_time(1'b0, 12, 59, 30); step(FLAG_TIME, FIELD_HOUR, 1'b0, 1'b1);
        cur_tag = "meridian_inc";  exp_time = mk_time(1'b1, 12, 59, 30); step(FLAG_TIME, FIELD_MERIDIAN, 1'b1, 1'b0);
        cur_tag = "meridian_dec";  exp_time = mk_time(1'b0, 12, 59, 30); step(FLAG_TIME, FIELD_MERIDIAN, 1'b0, 1'b1);
    endtask

    task automatic test_calendar();
        cur_tag = "leap_day_wrap"; exp_date = mk_date(24, 2, 1);  step(FLAG_TIME, FIELD_DAY, 1'b1, 1'b0);
        cur_tag = "leap_day_dec";  exp_date = mk_date(24, 2, 29); step(FLAG_TIME, FIELD_DAY, 1'b0, 1'b1);
        cur_tag = "year_clamp";    exp_date = mk_date(25, 2, 28); step(FLAG_TIME, FIELD_YEAR, 1'b1, 1'b0);
        cur_tag = "year_dec";      exp_date = mk_date(24, 2, 28); step(FLAG_TIME, FIELD_YEAR, 1'b0, 1'b1);
        cur_tag = "month_dec";     exp_date = mk_date(24, 1, 28); step(FLAG_TIME, FIELD_MONTH, 1'b0, 1'b1);
        for (int d = 29; d <= 31; d++) begin
            cur_tag  = "day_inc";
            exp_date = mk_date(24, 1, d);
            step(FLAG_TIME, FIELD_DAY, 1'b1, 1'b0);
        end
        cur_tag = "month_clamp";   exp_date = mk_date(24, 2, 29); step(FLAG_TIME, FIELD_MONTH, 1'b1, 1'b0);
        cur_tag = "month_inc";     exp_date = mk_date(24, 3, 29); step(FLAG_TIME, FIELD_MONTH, 1'b1, 1'b0);
    endtask

    task automatic test_ignored();
        cur_tag = "inc_dec_both";  step(FLAG_TIME, FIELD_DAY, 1'b1, 1'b1);
        cur_tag = "field_none";    step(FLAG_TIME, FIELD_NONE, 1'b1, 1'b0);
    endtask

    task automatic test_cancel();
        cur_tag = "cancel";
        exp_ed  = 1'b0;
        step(FLAG_CANCEL, FIELD_SEC, 1'b1, 1'b0);
        cur_tag = "cancel_after";
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
    endtask

    task automatic test_commit();
        int lt_cnt = 0;
        int la_cnt = 0;
        cur_tag      = "commit_snap";
        bus.CUR_TIME = mk_time(1'b0, 3, 15, 4);
        bus.CUR_DATE = mk_date(0, 12, 31);
        exp_time     = mk_time(1'b0, 3, 15, 4);
        exp_date     = mk_date(0, 12, 31);
        exp_ed       = 1'b1;
        step(FLAG_TIME, FIELD_NONE, 1'b0, 1'b0);
        cur_tag  = "commit_sec_inc";
        exp_time = mk_time(1'b0, 3, 15, 5);
        step(FLAG_TIME, FIELD_SEC, 1'b1, 1'b0);
        cur_tag = "commit_done_inc_dropped";
        step(FLAG_DONE, FIELD_SEC, 1'b1, 1'b0);
        lt_cnt += int'(bus.LOAD_TIME);
        la_cnt += int'(bus.LOAD_ALARM);
        cur_tag = "commit_load";
        exp_ed  = 1'b0;
        exp_lt  = 1'b1;
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
        lt_cnt += int'(bus.LOAD_TIME);
        la_cnt += int'(bus.LOAD_ALARM);
        cur_tag = "commit_after";
        exp_lt  = 1'b0;
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
        lt_cnt += int'(bus.LOAD_TIME);
        la_cnt += int'(bus.LOAD_ALARM);
        checks++;
        if (lt_cnt != 1 || la_cnt != 0) begin
            errors++;
            $display("FAIL commit_pulses LOAD_TIME/LOAD_ALARM pulses got %0d/%0d want 1/0", lt_cnt, la_cnt);
        end
    endtask

    task automatic test_alarm();
        int la_cnt = 0;
        cur_tag      = "alarm_snap";
        bus.CUR_DATE = mk_date(30, 7, 15);
        exp_time     = mk_time(1'b1, 6, 30, 0);
        exp_ed       = 1'b1;
        step(FLAG_ALARM, FIELD_NONE, 1'b0, 1'b0);
        cur_tag = "alarm_year_ignored"; step(FLAG_ALARM, FIELD_YEAR, 1'b1, 1'b0);
        cur_tag = "alarm_day_ignored";  step(FLAG_ALARM, FIELD_DAY, 1'b0, 1'b1);
        cur_tag  = "alarm_hour_inc";
        exp_time = mk_time(1'b1, 7, 30, 0);
        step(FLAG_ALARM, FIELD_HOUR, 1'b1, 1'b0);
        cur_tag = "alarm_done";
        step(FLAG_DONE, FIELD_NONE, 1'b0, 1'b0);
        la_cnt += int'(bus.LOAD_ALARM);
        cur_tag = "alarm_load";
        exp_ed  = 1'b0;
        exp_la  = 1'b1;
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
        la_cnt += int'(bus.LOAD_ALARM);
        cur_tag = "alarm_after";
        exp_la  = 1'b0;
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
        la_cnt += int'(bus.LOAD_ALARM);
        checks++;
        if (la_cnt != 1) begin
            errors++;
            $display("FAIL alarm_pulses LOAD_ALARM pulses got %0d want 1", la_cnt);
        end
    endtask

    task automatic test_abort();
        cur_tag  = "abort_snap";
        exp_time = mk_time(1'b0, 3, 15, 4);
        exp_date = mk_date(30, 7, 15);
        exp_ed   = 1'b1;
        step(FLAG_TIME, FIELD_NONE, 1'b0, 1'b0);
        cur_tag = "abort_undefined_flag";
        exp_ed  = 1'b0;
        step(3'b111, FIELD_MIN, 1'b1, 1'b0);
        cur_tag = "abort_after";
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        cur_tag = "midreset_snap";
        exp_ed  = 1'b1;
        step(FLAG_TIME, FIELD_NONE, 1'b0, 1'b0);
        cur_tag  = "midreset_min_inc";
        exp_time = mk_time(1'b0, 3, 16, 4);
        step(FLAG_TIME, FIELD_MIN, 1'b1, 1'b0);
        cur_tag  = "midreset_reset";
        RESETN   = 1'b0;
        exp_time = 17'h0C000;
        exp_date = 16'h0021;
        exp_ed   = 1'b0;
        step(FLAG_DONE, FIELD_NONE, 1'b0, 1'b0);
        cur_tag = "midreset_held_flag";
        RESETN  = 1'b1;
        step(FLAG_TIME, FIELD_NONE, 1'b0, 1'b0);
        cur_tag = "midreset_after";
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
        step(FLAG_NONE, FIELD_NONE, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish within 100000 time units");
        $fatal(1);
    end

    initial begin
        RESETN         = 1'b0;
        bus.FLAG       = FLAG_NONE;
        bus.FIELD      = FIELD_NONE;
        bus.INC        = 1'b0;
        bus.DEC        = 1'b0;
        bus.CUR_TIME   = '0;
        bus.CUR_DATE   = '0;
        bus.ALARM_TIME = '0;

        test_reset();
        test_snapshot();
        test_wrap();
        test_calendar();
        test_ignored();
        test_cancel();
        test_commit();
        test_alarm();
        test_abort();
        test_reset_mid();

        repeat (4) begin
            if (sb.size() == 0) break;
            @(negedge CLK);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain scoreboard entries left got %0d want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
